cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder_pkg.sv | 21 ++
 rtl/cla_pipe_adder_if.sv | 29 ++
 rtl/cla_pipe_adder_group4.sv | 24 ++
 rtl/cla_pipe_adder.sv | 145 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder:
// op encoding, default width and 4-bit group propagate/generate helpers.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned GRP_BITS  = 4;

  function automatic logic grp_pg(input logic [3:0] p);
    return &p;
  endfunction

  function automatic logic grp_gg(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder; master drives operands
// and out_ready, slave returns in_ready and the registered result.
interface cla_pipe_adder_if
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder_group4.sv
// 4-bit lookahead group: internal carries from p/g/cin, sum bits and
// group-level propagate/generate for the next lookahead level.
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       pg,
  output logic       gg
);
  logic [3:0] c;

  always_comb begin
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    pg   = grp_pg(p);
    gg   = grp_gg(p, g);
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake: stage 1 registers bit and group P/G, stage 2 resolves carries.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned GROUP = GRP_BITS
) (
  input logic              clk,
  input logic              rst_n,
  cla_pipe_adder_if.slave  bus
);
  localparam int unsigned NG = WIDTH / GROUP;

  // Stage 1: operand conditioning and P/G capture
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [NG-1:0]    pg_in;
  logic [NG-1:0]    gg_in;
  logic             c0_in;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NG-1:0]    s1_pg;
  logic [NG-1:0]    s1_gg;
  logic             s1_c0;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout;
  logic             s2_ovf;

  logic             adv2;
  logic             in_ready;
  logic             in_fire;

  always_comb begin
    is_sub = (op_e'(bus.op) == OP_SUB);
    b_eff  = is_sub ? ~bus.b : bus.b;
    p_in   = bus.a ^ b_eff;
    g_in   = bus.a & b_eff;
    c0_in  = is_sub ? 1'b1 : bus.cin;
    pg_in  = '0;
    gg_in  = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      pg_in[k] = grp_pg(p_in[4*k +: 4]);
      gg_in[k] = grp_gg(p_in[4*k +: 4], g_in[4*k +: 4]);
    end
  end

  assign adv2     = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || adv2;
  assign in_fire  = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_p  <= p_in;
      s1_g  <= g_in;
      s1_pg <= pg_in;
      s1_gg <= gg_in;
      s1_c0 <= c0_in;
    end
  end

  // Stage 2: each group carry is a flat OR of products over the registered
  // group P/G (no group-to-group ripple), c_grp[NG] being the final carry.
  logic [NG:0]      c_grp;
  logic             term;
  logic             acc;
  logic [WIDTH-1:0] sum_next;
  logic [NG-1:0]    unused_pg;
  logic [NG-1:0]    unused_gg;
  logic             c_msb;
  logic             ovf_next;

  always_comb begin
    c_grp    = '0;
    term     = 1'b0;
    acc      = 1'b0;
    c_grp[0] = s1_c0;
    for (int unsigned k = 1; k <= NG; k++) begin
      term = s1_c0;
      for (int unsigned i = 0; i < k; i++) begin
        term = term & s1_pg[i];
      end
      acc = term;
      for (int unsigned j = 0; j < k; j++) begin
        term = s1_gg[j];
        for (int unsigned i = j + 1; i < k; i++) begin
          term = term & s1_pg[i];
        end
        acc = acc | term;
      end
      c_grp[k] = acc;
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .p   (s1_p[4*k +: 4]),
      .g   (s1_g[4*k +: 4]),
      .cin (c_grp[k]),
      .sum (sum_next[4*k +: 4]),
      .pg  (unused_pg[k]),
      .gg  (unused_gg[k])
    );
  end

  // Sum bit is p ^ carry-in, so the carry into the MSB falls out of it.
  assign c_msb    = sum_next[WIDTH-1] ^ s1_p[WIDTH-1];
  assign ovf_next = c_msb ^ c_grp[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum  <= sum_next;
        s2_cout <= c_grp[NG];
        s2_ovf  <= ovf_next;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.sum       = s2_sum;
  assign bus.cout      = s2_cout;
  assign bus.ovf       = s2_ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16): directed corner cases,
// streaming, backpressure, async reset and randomized traffic vs. an arithmetic model.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus ();

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int failed    = 0;

  // Reference result {ovf, cout, sum} from integer arithmetic.
  function automatic logic [17:0] ref_result(input logic opv, input logic [15:0] av,
                                             input logic [15:0] bv, input logic cv);
    int u;
    int s;
    logic co;
    logic ov;
    if (opv) begin
      u  = int'(av) - int'(bv);
      co = (u >= 0);
      s  = int'($signed(av)) - int'($signed(bv));
    end else begin
      u  = int'(av) + int'(bv) + int'(cv);
      co = (u > 65535);
      s  = int'($signed(av)) + int'($signed(bv)) + int'(cv);
    end
    ov = (s > 32767) || (s < -32768);
    return {ov, co, 16'(u)};
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    tests_run++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      failed++; $display("FAIL reset_outputs got sum=%h cout=%b ovf=%b exp 0000/0/0",
                         bus.sum, bus.cout, bus.ovf);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      failed++; $display("FAIL post_reset_out_valid got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic run_beat(input logic opv, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, output logic [15:0] s, output logic co,
                          output logic ov, output int lat, output logic acc);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = opv;
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = cv;
    #1;
    acc = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    s   = '0;
    co  = 1'b0;
    ov  = 1'b0;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (bus.out_valid) begin
      s  = bus.sum;
      co = bus.cout;
      ov = bus.ovf;
    end
    tick();
  endtask

  task automatic test_directed();
    logic        t_op  [7] = '{0, 0, 0, 1, 1, 0, 1};
    logic [15:0] t_a   [7] = '{16'h00FF, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000, 16'h1234, 16'h1234};
    logic [15:0] t_b   [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4321, 16'h1234};
    logic        t_cin [7] = '{0, 0, 1, 1, 0, 1, 0};
    logic [15:0] e_sum [7] = '{16'h0100, 16'h8000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h5556, 16'h0000};
    logic        e_co  [7] = '{0, 0, 1, 0, 1, 0, 1};
    logic        e_ov  [7] = '{0, 1, 0, 0, 1, 0, 0};
    logic [15:0] s;
    logic        co;
    logic        ov;
    logic        acc;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      run_beat(t_op[i], t_a[i], t_b[i], t_cin[i], s, co, ov, lat, acc);
      tests_run++;
      if (acc !== 1'b1) begin
        failed++; $display("FAIL dir%0d_accept got=%b exp=1", i, acc);
      end
      tests_run++;
      if (lat != 2) begin
        failed++; $display("FAIL dir%0d_latency got=%0d exp=2", i, lat);
      end
      tests_run++;
      if (s !== e_sum[i]) begin
        failed++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, e_sum[i]);
      end
      tests_run++;
      if (co !== e_co[i]) begin
        failed++; $display("FAIL dir%0d_cout got=%b exp=%b", i, co, e_co[i]);
      end
      tests_run++;
      if (ov !== e_ov[i]) begin
        failed++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ov, e_ov[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s;
    idle_inputs();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        bus.in_valid = 1'b1;
        bus.op       = 1'b0;
        bus.a        = 16'(c * 16'h1111);
        bus.b        = 16'h0101;
        bus.cin      = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c < 6) begin
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
          failed++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, bus.in_ready);
        end
      end
      if (c >= 2) begin
        exp_s = 16'((c - 2) * 16'h1111 + 16'h0101);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.sum !== exp_s) begin
          failed++; $display("FAIL b2b_result c=%0d got valid=%b sum=%h exp valid=1 sum=%h",
                             c, bus.out_valid, bus.sum, exp_s);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    int idx = 0;
    idle_inputs();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = vals[idx];
      bus.b        = 16'h0000;
      #1;
      if (bus.in_ready) idx++;
      tick();
    end
    #1;
    tests_run++;
    if (idx != 2) begin
      failed++; $display("FAIL bp_accepted got=%0d exp=2", idx);
    end
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      failed++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready);
    end
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 16'h0001) begin
      failed++; $display("FAIL bp_hold got valid=%b sum=%h exp valid=1 sum=0001",
                         bus.out_valid, bus.sum);
    end
    for (int c = 0; c < 4; c++) begin
      bus.out_ready = 1'b1;
      if (idx < 4) begin
        bus.in_valid = 1'b1;
        bus.a        = vals[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.sum !== 16'(c + 1)) begin
        failed++; $display("FAIL bp_drain c=%0d got valid=%b sum=%h exp valid=1 sum=%h",
                           c, bus.out_valid, bus.sum, 16'(c + 1));
      end
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
    end
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || idx != 4) begin
      failed++; $display("FAIL bp_empty got valid=%b accepted=%0d exp valid=0 accepted=4",
                         bus.out_valid, idx);
    end
  endtask

  task automatic test_async_reset();
    int acc = 0;
    idle_inputs();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6 && acc < 2; c++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'(5 + acc);
      #1;
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    tests_run++;
    if (acc != 2 || bus.out_valid !== 1'b1) begin
      failed++; $display("FAIL arst_setup got accepted=%0d valid=%b exp accepted=2 valid=1",
                         acc, bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000) begin
      failed++; $display("FAIL arst_immediate got valid=%b sum=%h exp valid=0 sum=0000",
                         bus.out_valid, bus.sum);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL arst_in_ready got=%b exp=1", bus.in_ready);
    end
    tick();
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        failed++; $display("FAIL arst_stale c=%0d got valid=%b sum=%h exp valid=0",
                           c, bus.out_valid, bus.sum);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    logic [17:0] exp_q [$];
    logic [17:0] got_v;
    int sent   = 0;
    int got    = 0;
    int cycles = 0;
    idle_inputs();
    while ((sent < N || exp_q.size() > 0) && cycles < 60000) begin
      if (sent < N) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.op       = 1'($urandom_range(0, 1));
        bus.a        = pick_operand();
        bus.b        = pick_operand();
        bus.cin      = 1'($urandom_range(0, 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid) begin
        got_v = {bus.ovf, bus.cout, bus.sum};
        tests_run++;
        if (exp_q.size() == 0) begin
          failed++; $display("FAIL rnd_extra got=%h exp=no result pending", got_v);
        end else begin
          if (got_v !== exp_q[0]) begin
            failed++; $display("FAIL rnd_result beat=%0d got {ovf,cout,sum}=%h exp=%h",
                               got, got_v, exp_q[0]);
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_result(bus.op, bus.a, bus.b, bus.cin));
        sent++;
      end
      tick();
      cycles++;
    end
    tests_run++;
    if (got != N || exp_q.size() != 0) begin
      failed++; $display("FAIL rnd_count got=%0d pending=%0d exp=%0d pending=0",
                         got, exp_q.size(), N);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
